// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter
// on the same link.
package uart_pkg;

  localparam int UART_FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  function automatic int baud_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchronizer for asynchronous inputs, with a selectable
// reset value so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronizes rx_in, recovers frames with a
// mid-bit sampling FSM, and presents each good byte with a one-cycle strobe.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rx_sync
// START     | timing to mid start bit to confirm it is not a glitch
// DATA      | sampling 8 data bits, LSB first, one per baud period
// STOP      | sampling the stop bit; high = good frame, low = framing error
// WAIT_HIGH | line held low after a bad stop bit, wait for it to release
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] status_leds
);

  localparam int BAUD_PERIOD = baud_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BAUD_PERIOD / 2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_PERIOD - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(UART_FRAME_BITS - 1);

  if (BAUD_PERIOD < 4 || BAUD_PERIOD > 65535) begin : g_bad_baud
    $error("uart_receiver: CLK_FREQ/BAUD_RATE must lie in 4..65535");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 8) begin : g_bad_width
    $error("uart_receiver: DATA_WIDTH must lie in 1..8");
  end

  logic           rx_sync;
  uart_rx_state_t state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_d;
  logic           valid_d, ferr_d;

  sync_2ff #(.RESET_VALUE(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
      status_leds <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_out    <= data_d;
      data_valid  <= valid_d;
      frame_error <= ferr_d;
      busy        <= (state_d != IDLE);
      if (valid_d) status_leds <= data_d[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_out;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          if (!rx_sync) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BAUD_LAST) begin
          shift_d[bit_idx_q] = rx_sync;
          cnt_d              = '0;
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // A held-low line (break) must release before a new start is accepted.
      WAIT_HIGH: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 10 clocks per bit: expected bytes
// are queued as frames are driven and matched against each data_valid.
module tb_uart_receiver;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int DW        = 4;
  localparam int BIT       = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_in = 1'b1;
  logic [7:0]    data_out;
  logic          data_valid;
  logic          frame_error;
  logic          busy;
  logic [DW-1:0] status_leds;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy),
    .status_leds (status_leds)
  );

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         dv_count = 0;
  int         fe_count = 0;
  int         cyc = 0;
  int         last_dv_cyc = 0;
  int         prev_dv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every data_valid must match the oldest queued byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        dv_count++;
        prev_dv_cyc = last_dv_cyc;
        last_dv_cyc = cyc;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_valid: data_out=%h, none expected", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_out !== mon_exp || status_leds !== mon_exp[DW-1:0])
            $display("FAIL scoreboard: data_out=%h leds=%h, expected %h leds=%h",
                     data_out, status_leds, mon_exp, mon_exp[DW-1:0]);
          else
            pass_cnt++;
        end
      end
      if (frame_error) fe_count++;
      if (data_valid && frame_error) begin
        total_cnt++;
        $display("FAIL valid_and_error: both high at cycle %0d, expected exclusive", cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    rx_in = b;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_len = BIT);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
    send_bit(1'b1, stop_len);
  endtask

  task automatic wait_queue_empty();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_in = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    total_cnt++;
    if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h, expected 00", data_out);
    else pass_cnt++;
    total_cnt++;
    if (data_valid !== 1'b0 || frame_error !== 1'b0)
      $display("FAIL reset_strobes: valid=%b err=%b, expected 0 0", data_valid, frame_error);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (status_leds !== 4'h0) $display("FAIL reset_leds: got %h, expected 0", status_leds);
    else pass_cnt++;
  endtask

  task automatic test_single_frame();
    int dv0, fe0;
    dv0 = dv_count;
    fe0 = fe_count;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5);
    tick(5);
    wait_queue_empty();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL single_drain: %0d pending, expected 0", exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (dv_count - dv0 != 1 || fe_count != fe0)
      $display("FAIL single_pulses: valid=%0d err=%0d, expected 1 0", dv_count - dv0, fe_count - fe0);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'hA5 || status_leds !== 4'h5)
      $display("FAIL single_hold: data_out=%h leds=%h, expected a5 5", data_out, status_leds);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dv0;
    dv0 = dv_count;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00);
    send_frame(8'hFF);
    tick(5);
    wait_queue_empty();
    total_cnt++;
    if (dv_count - dv0 != 2) $display("FAIL b2b_count: got %0d pulses, expected 2", dv_count - dv0);
    else pass_cnt++;
    total_cnt++;
    if (last_dv_cyc - prev_dv_cyc != 100)
      $display("FAIL b2b_spacing: got %0d cycles, expected 100", last_dv_cyc - prev_dv_cyc);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'hFF) $display("FAIL b2b_last: got %h, expected ff", data_out);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int dv0, fe0;
    logic seen;
    dv0  = dv_count;
    fe0  = fe_count;
    seen = 1'b0;
    rx_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) rx_in = 1'b1;
      tick(1);
      if (busy) seen = 1'b1;
    end
    tick(10);
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL glitch_busy_pulse: busy seen=%b, expected 1", seen);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL glitch_idle: busy=%b, expected 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (dv_count != dv0 || fe_count != fe0 || data_out !== 8'hFF)
      $display("FAIL glitch_quiet: valid=%0d err=%0d data_out=%h, expected 0 0 ff",
               dv_count - dv0, fe_count - fe0, data_out);
    else pass_cnt++;
  endtask

  task automatic test_frame_error();
    int dv0, fe0;
    logic [7:0] d;
    dv0 = dv_count;
    fe0 = fe_count;
    d   = 8'h3C;
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
    send_bit(1'b0, 25);
    total_cnt++;
    if (busy !== 1'b1 || fe_count - fe0 != 1)
      $display("FAIL ferr_wait_high: busy=%b errs=%0d, expected 1 1", busy, fe_count - fe0);
    else pass_cnt++;
    send_bit(1'b0, 5);
    rx_in = 1'b1;
    tick(5);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL ferr_release: busy=%b, expected 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (fe_count - fe0 != 1 || dv_count != dv0 || data_out !== 8'hFF)
      $display("FAIL ferr_pulses: errs=%0d valid=%0d data_out=%h, expected 1 0 ff",
               fe_count - fe0, dv_count - dv0, data_out);
    else pass_cnt++;
    tick(10);
    exp_q.push_back(8'h11);
    send_frame(8'h11);
    tick(5);
    wait_queue_empty();
    total_cnt++;
    if (data_out !== 8'h11 || exp_q.size() != 0)
      $display("FAIL ferr_recover: data_out=%h pending=%0d, expected 11 0", data_out, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int dv0, fe0;
    logic [7:0] d;
    d = 8'h5A;
    send_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) send_bit(d[i], BIT);
    rx_in = d[4];
    tick(5);
    dv0 = dv_count;
    fe0 = fe_count;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rx_in = 1'b1;
    total_cnt++;
    if (data_out !== 8'h00 || status_leds !== 4'h0 || busy !== 1'b0 || data_valid !== 1'b0)
      $display("FAIL midreset_values: data_out=%h leds=%h busy=%b valid=%b, expected 00 0 0 0",
               data_out, status_leds, busy, data_valid);
    else pass_cnt++;
    tick(30);
    total_cnt++;
    if (dv_count != dv0 || fe_count != fe0 || busy !== 1'b0)
      $display("FAIL midreset_quiet: valid=%0d err=%0d busy=%b, expected 0 0 0",
               dv_count - dv0, fe_count - fe0, busy);
    else pass_cnt++;
    exp_q.push_back(8'h81);
    send_frame(8'h81);
    tick(5);
    wait_queue_empty();
    total_cnt++;
    if (data_out !== 8'h81 || exp_q.size() != 0)
      $display("FAIL midreset_next: data_out=%h pending=%0d, expected 81 0", data_out, exp_q.size());
    else pass_cnt++;
  endtask

  // Same waveform the transmitter produces for data_in=4'hC zero-extended.
  task automatic test_leds_mirror();
    exp_q.push_back(8'h0C);
    send_frame(8'h0C);
    tick(5);
    wait_queue_empty();
    total_cnt++;
    if (data_out !== 8'h0C || status_leds !== 4'hC)
      $display("FAIL leds_mirror: data_out=%h leds=%h, expected 0c c", data_out, status_leds);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    tick(5);
    test_single_frame();
    tick(5);
    test_back_to_back();
    tick(5);
    test_glitch();
    tick(5);
    test_frame_error();
    tick(5);
    test_reset_mid_frame();
    tick(5);
    test_leds_mirror();
    tick(20);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage; the downstream partner of the team's UART transmitter on the same link. It samples the asynchronous `rx_in` line and recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). Each good frame is presented as a byte with a single-cycle valid strobe. The low `DATA_WIDTH` bits are mirrored to board LEDs.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line bit rate.
- `DATA_WIDTH`, default 4: width of the `status_leds` mirror; must be ≤ 8.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_in` in 1: asynchronous serial line; idles high.
- `data_out` out 8: last correctly received byte.
- `data_valid` out 1: one-cycle pulse when `data_out` updates.
- `frame_error` out 1: one-cycle pulse when the stop bit is sampled low.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `status_leds` out DATA_WIDTH: equals `data_out[DATA_WIDTH-1:0]`, registered.

## Operation
- Constants:
  - BAUD_PERIOD = CLK_FREQ/BAUD_RATE (integer division).
  - HALF_PERIOD = BAUD_PERIOD/2.
  - Legal range: 4 ≤ BAUD_PERIOD ≤ 65535. Baud counter is 16 bits.
- Synchronizer:
  - `rx_in` passes through a 2-FF synchronizer, giving `rx_sync`. Both FFs reset to 1.
  - The FSM observes only `rx_sync`.
- FSM states and transitions:
  - **IDLE**: on `rx_sync`==0, clear the baud counter and go to START.
  - **START**: count to HALF_PERIOD-1, then sample.
    - Sample 0: clear counter and bit index, go to DATA.
    - Sample 1: treat as a glitch, return to IDLE with no pulse.
  - **DATA**: count to BAUD_PERIOD-1, then sample `rx_sync` into `shift[bit_idx]` and clear the counter.
    - After bit_idx==7, go to STOP; otherwise increment bit_idx.
  - **STOP**: count to BAUD_PERIOD-1, then sample.
    - Sample 1: load `data_out` and `status_leds` from `shift`, pulse `data_valid`, go to IDLE.
    - Sample 0: pulse `frame_error`, leave `data_out` unchanged, go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx_sync`==1, then go to IDLE. This prevents re-triggering during a break condition.
- No backpressure. A consumer must capture `data_out` on `data_valid`. `data_out` holds its value until the next good frame.
- `data_valid` and `frame_error` are never high in the same cycle.
- Reset at any point, including mid-frame, returns to IDLE and discards the partial byte.
- Reset values:
  - `data_out`=0, `data_valid`=0, `frame_error`=0, `busy`=0, `status_leds`=0.
  - Shift register=0, counters=0, synchronizer FFs=1.

## Timing
- `rx_in` falling edge to `rx_sync` falling: 2 cycles.
- Sample points are measured from the cycle START is entered:
  - Start bit: HALF_PERIOD cycles.
  - Data bit k (k=0..7): HALF_PERIOD + (k+1)·BAUD_PERIOD cycles.
  - Stop bit: HALF_PERIOD + 9·BAUD_PERIOD cycles.
- `data_valid`/`frame_error` are registered and go high in the cycle after the stop sample.
- `busy` is registered and rises one cycle after `rx_sync` falls. It drops in the same cycle that `data_valid` rises.
- Back-to-back frames are accepted: the FSM is in IDLE by mid-stop-bit + 1 cycle, so the next start edge is never missed.

## Structure
- Shared package `uart_pkg`:
  - State typedef `uart_rx_state_t` (IDLE, START, DATA, STOP, WAIT_HIGH).
  - `function baud_period(clk_freq, baud_rate)`, shared with the transmitter.
  - Constant `UART_FRAME_BITS` = 8.
- One sub-module: `sync_2ff`, a parameterizable reset value bit synchronizer, reusable for other async inputs.
- All other logic is flat in `uart_receiver`.

## Test plan
Bench setting: CLK_FREQ=1_000_000, BAUD_RATE=100_000, giving BAUD_PERIOD=10 and HALF_PERIOD=5.
- Single frame 0xA5 driven at 10 cycles/bit → one `data_valid` pulse, `data_out`=8'hA5, `status_leds`=4'h5, `frame_error` never high.
- Frames 0x00 then 0xFF back-to-back with a stop bit of exactly 10 cycles → two `data_valid` pulses exactly 100 cycles apart, values 8'h00 and 8'hFF.
- 3-cycle low glitch on `rx_in` → `busy` pulses, returns to IDLE, no `data_valid` or `frame_error`, `data_out` unchanged.
- Frame 0x3C with stop bit held low for 30 cycles → one `frame_error` pulse, no `data_valid`, `data_out` keeps its prior value. The FSM stays in WAIT_HIGH until the line returns high, and a following 0x11 frame is received correctly.
- `reset` asserted for 1 cycle during data bit 4 of frame 0x5A → all outputs return to reset values, no pulse. The next clean frame 0x81 yields `data_out`=8'h81.
- Loopback from `uart_transmitter` (same parameters, DATA_WIDTH=4, `data_in`=4'hC, `transmit_en` pulsed) → `data_valid` with `data_out`=8'h0C and `status_leds`=4'hC.
